// File: rtl/b02_seq_detect_if.sv
// b02_seq_detect_if: control/data bundle for the b02_seq_detect pattern
// recognizer. The clock and reset are not part of the bundle.
//   master: drives ENABLE, LINEA, LINEA_VALID, PAT_LOAD, PAT_IN, CNT_CLR;
//           observes U_REG, MATCH_CNT, CNT_SAT, ARMED.
//   slave : the recognizer side (opposite directions).
interface b02_seq_detect_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             ENABLE;
  logic             LINEA;
  logic             LINEA_VALID;
  logic             PAT_LOAD;
  logic [PAT_W-1:0] PAT_IN;
  logic             CNT_CLR;
  logic             U_REG;
  logic [CNT_W-1:0] MATCH_CNT;
  logic             CNT_SAT;
  logic             ARMED;

  modport master (
    output ENABLE, LINEA, LINEA_VALID, PAT_LOAD, PAT_IN, CNT_CLR,
    input  U_REG, MATCH_CNT, CNT_SAT, ARMED
  );

  modport slave (
    input  ENABLE, LINEA, LINEA_VALID, PAT_LOAD, PAT_IN, CNT_CLR,
    output U_REG, MATCH_CNT, CNT_SAT, ARMED
  );
endinterface

// File: rtl/b02_seq_detect.sv
// b02_seq_detect: serial-line pattern recognizer. Shifts qualified LINEA
// bits MSB-first into a PAT_W-bit history and compares the last PAT_W bits
// against a runtime-loadable pattern. Each match gives a registered
// one-cycle U_REG pulse and bumps a saturating MATCH_CNT.
// Ports:
//   clock    - rising-edge clock
//   RESET_G  - asynchronous active-high reset
//   bus      - b02_seq_detect_if.slave (ENABLE, LINEA, LINEA_VALID,
//              PAT_LOAD, PAT_IN, CNT_CLR in; U_REG, MATCH_CNT, CNT_SAT,
//              ARMED out)
// Build option: define B02_SEQ_OVERLAP_EN to detect overlapping
// occurrences; otherwise each match restarts the fill from zero.
module b02_seq_detect #(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1011)
) (
  input  logic             clock,
  input  logic             RESET_G,
  b02_seq_detect_if.slave  bus
);

  localparam int FW = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] sr_q, sr_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             u_q, u_d;

  logic [PAT_W-1:0] sr_next;
  logic             match;
  logic             full_after;

  always_ff @(posedge clock or posedge RESET_G) begin
    if (RESET_G) begin
      state_q <= IDLE;
      sr_q    <= '0;
      fill_q  <= '0;
      pat_q   <= PAT_RST;
      cnt_q   <= '0;
      u_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      u_q     <= u_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    fill_d     = fill_q;
    pat_d      = pat_q;
    cnt_d      = cnt_q;
    match      = 1'b0;
    sr_next    = {sr_q[PAT_W-2:0], bus.LINEA};
    // fill+1 >= PAT_W, i.e. this bit completes a full window
    full_after = (fill_q >= FW'(PAT_W - 1));

    // Pattern load is independent of ENABLE; it also blocks acceptance.
    if (bus.PAT_LOAD) pat_d = bus.PAT_IN;

    if (!bus.ENABLE) begin
      state_d = IDLE;
      sr_d    = '0;
      fill_d  = '0;
    end else if (bus.PAT_LOAD) begin
      state_d = FILL;
      sr_d    = '0;
      fill_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = FILL;
        FILL, HUNT: begin
          if (bus.LINEA_VALID) begin
            match   = full_after && (sr_next == pat_q);
            sr_d    = sr_next;
            fill_d  = (fill_q == FW'(PAT_W)) ? fill_q : fill_q + FW'(1);
            state_d = full_after ? HUNT : FILL;
`ifndef B02_SEQ_OVERLAP_EN
            if (match) begin
              sr_d    = '0;
              fill_d  = '0;
              state_d = FILL;
            end
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Clear wins over a coincident increment.
    if (bus.CNT_CLR) cnt_d = '0;
    else if (match && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);

    u_d = match;
  end

  assign bus.U_REG     = u_q;
  assign bus.MATCH_CNT = cnt_q;
  assign bus.CNT_SAT   = &cnt_q;
  assign bus.ARMED     = (state_q == HUNT);

endmodule

// File: doc/b02_seq_detect.md
# b02_seq_detect

Parametrised serial-line pattern recognizer, successor to the fixed three-bit-state b02 FSM. It samples a qualified serial bit stream on LINEA and compares the last PAT_W bits against a runtime-loadable pattern. On each match it emits a one-cycle U_REG pulse and increments a saturating match counter. It sits directly on the serial input path, alongside the other b0x control FSMs.

## Interface
- PAT_W, 4: pattern length in bits; legal range 2..32.
- CNT_W, 8: match counter width; legal range 1..32.
- PAT_RST, 4'b1011: pattern register value after reset; width PAT_W.
- clock  input  1  single clock; all state updates on its rising edge.
- RESET_G  input  1  asynchronous, active-high reset.
- ENABLE  input  1  run enable; low forces IDLE.
- LINEA  input  1  serial data bit.
- LINEA_VALID  input  1  LINEA is sampled only on edges where this is high.
- PAT_LOAD  input  1  loads PAT_IN into the pattern register.
- PAT_IN  input  PAT_W  new pattern; MSB is the oldest bit.
- CNT_CLR  input  1  synchronous clear of MATCH_CNT.
- U_REG  output  1  match pulse, registered.
- MATCH_CNT  output  CNT_W  saturating count of matches.
- CNT_SAT  output  1  high while MATCH_CNT is all-ones.
- ARMED  output  1  high in state HUNT.

## Operation
- History register sr[PAT_W-1:0] shifts MSB-first: sr <= {sr[PAT_W-2:0], LINEA} on each accepted bit.
- Fill counter counts accepted bits up to PAT_W. Its width is ceil(log2(PAT_W+1)).
- States:
  - IDLE: ENABLE low. sr = 0, fill = 0. Bits are ignored.
  - FILL: fewer than PAT_W bits accepted.
  - HUNT: sr holds PAT_W valid bits.
- Transitions:
  - IDLE→FILL when ENABLE is high.
  - FILL→HUNT on the bit that brings fill to PAT_W. That bit is also compared.
  - Any state→IDLE when ENABLE is low. sr and fill clear on that edge.
- Match: an accepted bit with (fill+1 ≥ PAT_W) and {sr[PAT_W-2:0], LINEA} == pattern.
- On a match:
  - U_REG=1 for exactly one cycle.
  - MATCH_CNT increments, saturating at 2^CNT_W−1.
- Bit accepted = state≠IDLE && ENABLE && LINEA_VALID && !PAT_LOAD.
- PAT_LOAD:
  - Pattern <= PAT_IN; sr and fill clear; state→FILL if ENABLE is high, else IDLE.
  - A same-cycle LINEA bit is discarded and no match is evaluated.
- CNT_CLR: MATCH_CNT <= 0. If a match occurs on the same edge, the clear wins (result 0) but U_REG still pulses.
- When no bit is accepted, sr, fill and state hold, and U_REG=0.

## Timing
- Reset values: U_REG=0, MATCH_CNT=0, CNT_SAT=0, ARMED=0, state=IDLE, sr=0, fill=0, pattern=PAT_RST.
- Reset takes effect immediately on assertion and is independent of clock. The first accepted bit is the first edge with RESET_G low and the acceptance conditions true.
- Match latency: the final bit is sampled at edge k; U_REG and MATCH_CNT update at edge k; U_REG drops at edge k+1 unless edge k+1 is also a match.
- Back-to-back matches, in overlap mode only, give U_REG high on consecutive cycles.
- CNT_SAT and ARMED are registered-state decodes with no extra latency.
- If reset asserts mid-FILL or mid-HUNT, partial history is lost; the pattern returns to PAT_RST.

## Configuration
- B02_SEQ_OVERLAP_EN defined: after a match, fill stays at PAT_W and the state stays HUNT, so overlapping occurrences are detected.
- Undefined: on a match edge, sr and fill clear and the state returns to FILL. The next match needs PAT_W fresh bits, so occurrences do not overlap.

## Test plan
- Reset, ENABLE=1, bits 1,0,1,1 with LINEA_VALID=1 → U_REG pulse on the 4th bit's edge; MATCH_CNT=1; ARMED=1 (with overlap).
- Stream 1,0,1,1,0,1,1:
  - With B02_SEQ_OVERLAP_EN → two pulses (bits 4 and 7), MATCH_CNT=2.
  - Without → one pulse, MATCH_CNT=1.
- Bits 1,0 then LINEA_VALID low for 5 cycles with LINEA toggling, then 1,1 → one pulse, on the 4th valid bit only.
- PAT_LOAD=1 with PAT_IN=4'b0110, in the same cycle as a valid bit, mid-stream → bit discarded, fill=0; next bits 0,1,1,0 → match.
- CNT_W=2, 4 matches → MATCH_CNT=3, CNT_SAT=1. Then CNT_CLR coincident with a match → MATCH_CNT=0 and U_REG=1.
- RESET_G pulse between clock edges during FILL → all outputs 0 before the next edge; pattern=1011; ENABLE=0 keeps ARMED=0 and ignores all bits.
